pixel_stream_sink: RTL and testbench



---
 rtl/pixel_stream_sink_pkg.sv | 20 ++
 rtl/pixel_stream_sink_sync_fifo.sv | 64 ++++++
 rtl/pixel_stream_sink.sv | 124 ++++++++++++
 tb/tb_pixel_stream_sink.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_sink_pkg.sv
// Shared definitions for the pixel stream sink: pixel width, FSM encodings,
// default frame geometry.
package pixel_stream_sink_pkg;

  localparam int PIX_W      = 24;
  localparam int DEF_WIDTH  = 768;
  localparam int DEF_HEIGHT = 512;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [PIX_W-1:0] pack_rgb(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/pixel_stream_sink_sync_fifo.sv
// First-word-fall-through FIFO; head entry is always visible on rdata.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 43,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              last
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]               cnt_q, cnt_d;
  logic                         do_push, do_pop;

  assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign last  = (cnt_q == (PTR_W+1)'(1));
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pixel_stream_sink.sv
// Receives an hsync-qualified RGB raster and writes each pixel to memory over a
// req/ack port, buffering through a FIFO and mapping raster order to addresses.
module pixel_stream_sink
  import pixel_stream_sink_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 19,
  parameter int BOTTOM_UP  = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              hsync,
  input  logic [7:0]        DATA_R,
  input  logic [7:0]        DATA_G,
  input  logic [7:0]        DATA_B,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  output logic              frame_done,
  output logic              overflow
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int ENT_W = ADDR_W + PIX_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } entry_t;

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             overflow_q, overflow_d;

  logic   accept, push, pop, drop, frame_start, last_pix, drain_done;
  logic   fifo_full, fifo_empty, fifo_last;
  logic [31:0] row_ext, addr_full;
  entry_t push_ent, head_ent;

  // Address is fixed at push time so the memory side never sees counter state.
  always_comb begin
    row_ext        = (BOTTOM_UP != 0) ? (32'(HEIGHT - 1) - 32'(row_q)) : 32'(row_q);
    addr_full      = row_ext * 32'(WIDTH) + 32'(col_q);
    push_ent.addr  = addr_full[ADDR_W-1:0];
    push_ent.data  = pack_rgb(DATA_R, DATA_G, DATA_B);
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    overflow_d  = overflow_q;
    pop         = mem_req && mem_ack;
    accept      = hsync && (state_q != ST_DRAIN);
    push        = accept && (!fifo_full || pop);
    drop        = hsync && !push;
    frame_start = accept && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    last_pix    = accept && (col_q == COL_LAST) && (row_q == ROW_LAST);
    drain_done  = fifo_empty || (fifo_last && pop);

    // Counters track sampled pixels, dropped or not, so addresses stay aligned.
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    if (frame_start) overflow_d = 1'b0;
    if (drop)        overflow_d = 1'b1;

    unique case (state_q)
      ST_IDLE, ST_DONE: if (hsync)      state_d = ST_RECV;
      ST_RECV:          if (last_pix)   state_d = ST_DRAIN;
      ST_DRAIN:         if (drain_done) state_d = ST_DONE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (pop),
    .wdata (push_ent),
    .rdata (head_ent),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last)
  );

  assign mem_req    = !fifo_empty;
  assign mem_addr   = head_ent.addr;
  assign mem_wdata  = head_ent.data;
  assign frame_done = (state_q == ST_DONE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Scoreboard bench for pixel_stream_sink: a 4x2 frame with a 4-deep FIFO,
// one bottom-up and one top-down instance fed the same stream.
module tb_pixel_stream_sink;
  import pixel_stream_sink_pkg::*;

  localparam int AW = 19;

  logic          HCLK = 1'b0, HRESET = 1'b0, hsync = 1'b0, mem_ack = 1'b0;
  logic [7:0]    r = '0, g = '0, b = '0;
  logic          req_a, req_b, fd_a, fd_b, ov_a, ov_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [23:0]   wd_a, wd_b;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int   n_chk = 0, n_pass = 0, wr_a = 0, wr_b = 0, base = 0;
  int   bu_addr[8] = '{4, 5, 6, 7, 0, 1, 2, 3};

  always #5 HCLK = ~HCLK;

  pixel_stream_sink #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .ADDR_W(AW), .BOTTOM_UP(1)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .hsync(hsync), .DATA_R(r), .DATA_G(g), .DATA_B(b),
    .mem_req(req_a), .mem_addr(addr_a), .mem_wdata(wd_a), .mem_ack(mem_ack),
    .frame_done(fd_a), .overflow(ov_a));

  pixel_stream_sink #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .ADDR_W(AW), .BOTTOM_UP(0)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .hsync(hsync), .DATA_R(r), .DATA_G(g), .DATA_B(b),
    .mem_req(req_b), .mem_addr(addr_b), .mem_wdata(wd_b), .mem_ack(mem_ack),
    .frame_done(fd_b), .overflow(ov_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic hs, input int pix, input logic [7:0] v, input logic store);
    hsync = hs;
    r = v; g = v; b = v;
    if (hs && store) begin
      q_a.push_back(exp_t'{AW'(bu_addr[pix]), {v, v, v}});
      q_b.push_back(exp_t'{AW'(pix), {v, v, v}});
    end
  endtask

  // Monitor: every accepted write is matched against the head of its queue.
  always @(negedge HCLK) begin
    if (!HRESET && mem_ack) begin
      if (req_a) begin
        wr_a++;
        if (q_a.size() == 0) begin
          n_chk++;
          $display("FAIL a_write: unexpected write addr 0x%0h data 0x%0h", addr_a, wd_a);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          check("a_addr", 32'(addr_a), 32'(e.addr));
          check("a_data", 32'(wd_a), 32'(e.data));
        end
      end
      if (req_b) begin
        wr_b++;
        if (q_b.size() == 0) begin
          n_chk++;
          $display("FAIL b_write: unexpected write addr 0x%0h data 0x%0h", addr_b, wd_b);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          check("b_addr", 32'(addr_b), 32'(e.addr));
          check("b_data", 32'(wd_b), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1 HRESET = 1'b1;
    repeat (2) tick();
    check("rst_req",   32'(req_a),  0);
    check("rst_addr",  32'(addr_a), 0);
    check("rst_wdata", 32'(wd_a),   0);
    check("rst_done",  32'(fd_a),   0);
    check("rst_ovf",   32'(ov_a),   0);
    check("rst_req_b", 32'(req_b),  0);
    HRESET = 1'b0;

    // Frame 1: ack tied high, pixels n,n,n.
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1'b1, i, 8'(i), 1'b1);
      if (i == 0) check("lat_before", 32'(req_a), 0);
      if (i == 1) begin
        check("lat_first_a", 32'(req_a), 1);
        check("lat_first_b", 32'(req_b), 1);
      end
    end
    tick(); drive(1'b0, 0, 8'h00, 1'b0);
    check("f1_done_early", 32'(fd_a), 0);
    tick();
    check("f1_done_a", 32'(fd_a), 1);
    check("f1_done_b", 32'(fd_b), 1);
    check("f1_ovf",    32'(ov_a), 0);
    check("f1_wr_a",   32'(wr_a), 8);
    check("f1_wr_b",   32'(wr_b), 8);

    // Frame 2: ack low, 6 pixels -> 4 stored, 2 dropped.
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(1'b1, i, 8'(8'h20 + i), i < 4);
    end
    tick(); drive(1'b0, 0, 8'h00, 1'b0);
    check("f2_ovf_a", 32'(ov_a), 1);
    check("f2_ovf_b", 32'(ov_b), 1);
    check("f2_req",   32'(req_a), 1);
    base = wr_a;
    mem_ack = 1'b1;
    repeat (6) tick();
    check("f2_drain_cnt",   32'(wr_a - base), 4);
    check("f2_req_idle",    32'(req_a), 0);
    check("f2_no_done_yet", 32'(fd_a), 0);
    for (int i = 6; i < 8; i++) begin
      tick();
      drive(1'b1, i, 8'(8'h20 + i), 1'b1);
    end
    tick(); drive(1'b0, 0, 8'h00, 1'b0);
    tick();
    check("f2_done",   32'(fd_a), 1);
    check("f2_sticky", 32'(ov_a), 1);
    check("f2_wr_cnt", 32'(wr_a - base), 6);

    // Frame 3: fill, then push and pop together while full.
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b1, i, 8'(8'h40 + i), 1'b1);
    end
    tick(); drive(1'b1, 4, 8'h44, 1'b1); mem_ack = 1'b1;
    tick(); drive(1'b0, 0, 8'h00, 1'b0); mem_ack = 1'b0;
    check("f3_full_no_drop", 32'(ov_a), 0);
    check("f3_ovf_cleared_b", 32'(ov_b), 0);
    base = wr_a;
    mem_ack = 1'b1;
    repeat (6) tick();
    check("f3_occupancy", 32'(wr_a - base), 4);
    for (int i = 5; i < 8; i++) begin
      tick();
      drive(1'b1, i, 8'(8'h40 + i), 1'b1);
    end
    tick(); drive(1'b0, 0, 8'h00, 1'b0);
    tick();
    check("f3_done", 32'(fd_a), 1);
    check("f3_ovf",  32'(ov_a), 0);

    // Frame 4: hold ack low at end of frame, then hsync during DRAIN.
    for (int i = 0; i < 7; i++) begin
      tick();
      drive(1'b1, i, 8'(8'h60 + i), 1'b1);
    end
    tick(); drive(1'b1, 7, 8'h67, 1'b1); mem_ack = 1'b0;
    tick(); drive(1'b1, 0, 8'hAA, 1'b0);
    tick(); drive(1'b0, 0, 8'h00, 1'b0);
    check("drain_drop_a", 32'(ov_a), 1);
    check("drain_drop_b", 32'(ov_b), 1);
    check("drain_busy",   32'(fd_a), 0);
    mem_ack = 1'b1;
    repeat (3) tick();
    check("drain_done", 32'(fd_a), 1);

    // Frame 5: three pixels queued, then reset mid-frame.
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b1, i, 8'(8'h80 + i), 1'b1);
    end
    tick(); drive(1'b0, 0, 8'h00, 1'b0);
    check("f5_ovf_cleared", 32'(ov_a), 0);
    check("f5_not_done",    32'(fd_a), 0);
    check("f5_req",         32'(req_a), 1);
    #1 HRESET = 1'b1;
    #1;
    check("rst_async_req_a", 32'(req_a), 0);
    check("rst_async_req_b", 32'(req_b), 0);
    check("rst_async_done",  32'(fd_a), 0);
    q_a.delete();
    q_b.delete();
    tick();
    HRESET = 1'b0;

    // Frame 6 after reset: starts at the row-0 address.
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1'b1, i, 8'(8'hC0 + i), 1'b1);
      if (i == 1) check("rst_row0_addr", 32'(addr_a), 4);
    end
    tick(); drive(1'b0, 0, 8'h00, 1'b0);
    tick();
    check("f6_done", 32'(fd_a), 1);
    check("f6_ovf",  32'(ov_a), 0);
    repeat (2) tick();
    check("sb_empty_a", 32'(q_a.size()), 0);
    check("sb_empty_b", 32'(q_b.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
